// File: rtl/mult_div_pkg.sv
// Shared encodings and default widths for the shift-add multiplier / shift-subtract divider pair.
package mult_div_pkg;
  localparam int WN = 8;
  localparam int WD = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/control_div.sv
// Divider sequencer: IDLE/CALC/DONE state machine plus the quotient-bit down-counter.
import mult_div_pkg::*;

module control_div #(
  parameter int WN = mult_div_pkg::WN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic dz_det,
  output logic load,
  output logic step,
  output logic latch_out,
  output logic busy,
  output logic done
);
  localparam int CW = (WN > 1) ? $clog2(WN) : 1;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          cnt_zero;

  // Handshake: init is level-sampled only in IDLE; done stays high until an edge sees init=0,
  // so a held init can never start a second operation.
  always_comb begin
    cnt_zero  = (cnt_q == '0);
    load      = (state_q == S_IDLE) && init;
    step      = (state_q == S_CALC);
    latch_out = (state_q == S_CALC) && cnt_zero;
    busy      = busy_q;
    done      = done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (init) begin
            if (dz_det) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
              cnt_q   <= CW'(WN - 1);
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_zero) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!init) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/div_8by4.sv
// Restoring shift-subtract divider, one quotient bit per clock; datapath inline, sequencing in control_div.
import mult_div_pkg::*;

module div_8by4 #(
  parameter int WN = mult_div_pkg::WN,
  parameter int WD = mult_div_pkg::WD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic [WN-1:0] dividend,
  input  logic [WD-1:0] divisor,
  output logic [WN-1:0] quotient,
  output logic [WD-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          dz
);
  logic [WN-1:0] nreg_q, nreg_d;
  logic [WD-1:0] rem_q, rem_d;
  logic [WD-1:0] d_q;
  logic [WN-1:0] quotient_q;
  logic [WD-1:0] remainder_q;
  logic          dz_q;
  logic [WD:0]   s, diff;
  logic          borrow;
  logic          dz_det, load, step, latch_out;

  // Since rem < D always holds, s < 2D, so a WD+1-bit difference already carries the borrow in its MSB.
  always_comb begin
    dz_det = (divisor == '0);
    s      = {rem_q, nreg_q[WN-1]};
    diff   = s - {1'b0, d_q};
    borrow = diff[WD];
    rem_d  = borrow ? s[WD-1:0] : diff[WD-1:0];
    nreg_d = {nreg_q[WN-2:0], ~borrow};
  end

  control_div #(.WN(WN)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .dz_det    (dz_det),
    .load      (load),
    .step      (step),
    .latch_out (latch_out),
    .busy      (busy),
    .done      (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nreg_q      <= '0;
      rem_q       <= '0;
      d_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
    end else if (load) begin
      nreg_q <= dividend;
      rem_q  <= '0;
      d_q    <= divisor;
      if (dz_det) begin
        quotient_q  <= '1;
        remainder_q <= '0;
        dz_q        <= 1'b1;
      end
    end else if (step) begin
      nreg_q <= nreg_d;
      rem_q  <= rem_d;
      if (latch_out) begin
        quotient_q  <= nreg_d;
        remainder_q <= rem_d;
        dz_q        <= 1'b0;
      end
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dz        = dz_q;
endmodule
